// File: rtl/mux4_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mux4_scan_ctrl
// Purpose  : Round-robin scanner driving the sel1/sel0 pair of a 4:1 mux, with
//            a per-grant beat dwell and a valid/ready handshake to the consumer.
// Revision : 1.0 - initial release
// ============================================================================
module mux4_scan_ctrl #(
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [3:0]         req,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               ready,
    output logic               sel1,
    output logic               sel0,
    output logic               valid,
    output logic               ch_done,
    output logic               busy
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [DWELL_W-1:0] c_DWELL_MIN = DWELL_W'(1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [1:0]         r_rr_ptr;
    logic [1:0]         w_rr_ptr_nxt;
    logic [1:0]         r_sel;
    logic [1:0]         w_sel_nxt;
    logic               r_valid;
    logic               w_valid_nxt;
    logic               r_ch_done;
    logic               w_ch_done_nxt;
    logic [DWELL_W-1:0] r_beat_cnt;
    logic [DWELL_W-1:0] w_beat_cnt_nxt;
    logic [DWELL_W-1:0] r_dwell_lat;
    logic [DWELL_W-1:0] w_dwell_lat_nxt;

    logic               w_arb_req;
    logic               w_accept;
    logic               w_last;
    logic [1:0]         w_ptr_after;
    logic [DWELL_W-1:0] w_dwell_eff;

    // Rotate req so bit k is channel (ptr+k) mod 4, then take the lowest set bit.
    function automatic logic [1:0] f_rr_pick(input logic [1:0] ptr, input logic [3:0] rq);
        logic [7:0] dbl;
        logic [3:0] rot;
        logic [1:0] off;
        dbl = {rq, rq};
        rot = 4'(dbl >> ptr);
        if (rot[0])      off = 2'd0;
        else if (rot[1]) off = 2'd1;
        else if (rot[2]) off = 2'd2;
        else             off = 2'd3;
        return ptr + off;
    endfunction

    assign w_arb_req   = en && (req != 4'b0000);
    assign w_accept    = (r_state == GRANT) && r_valid && ready;
    // Widened compare so a full-scale dwell cannot wrap the beat count.
    assign w_last      = w_accept &&
                         ((DWELL_W+1)'(r_beat_cnt) + (DWELL_W+1)'(1) == (DWELL_W+1)'(r_dwell_lat));
    assign w_ptr_after = r_sel + 2'd1;
    assign w_dwell_eff = (dwell == '0) ? c_DWELL_MIN : dwell;

    always_comb begin
        w_state_nxt     = r_state;
        w_rr_ptr_nxt    = r_rr_ptr;
        w_sel_nxt       = r_sel;
        w_valid_nxt     = r_valid;
        w_ch_done_nxt   = 1'b0;
        w_beat_cnt_nxt  = r_beat_cnt;
        w_dwell_lat_nxt = r_dwell_lat;

        case (r_state)
            IDLE: begin
                if (w_arb_req) begin
                    w_state_nxt     = GRANT;
                    w_sel_nxt       = f_rr_pick(r_rr_ptr, req);
                    w_valid_nxt     = 1'b1;
                    w_beat_cnt_nxt  = '0;
                    w_dwell_lat_nxt = w_dwell_eff;
                end
            end
            GRANT: begin
                if (w_last) begin
                    w_ch_done_nxt  = 1'b1;
                    w_rr_ptr_nxt   = w_ptr_after;
                    w_beat_cnt_nxt = '0;
                    // Back-to-back grant arbitrates from the freshly advanced pointer.
                    if (w_arb_req) begin
                        w_sel_nxt       = f_rr_pick(w_ptr_after, req);
                        w_dwell_lat_nxt = w_dwell_eff;
                    end else begin
                        w_state_nxt = IDLE;
                        w_valid_nxt = 1'b0;
                    end
                end else if (w_accept) begin
                    w_beat_cnt_nxt = r_beat_cnt + DWELL_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_rr_ptr    <= 2'd0;
            r_sel       <= 2'd0;
            r_valid     <= 1'b0;
            r_ch_done   <= 1'b0;
            r_beat_cnt  <= '0;
            r_dwell_lat <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_rr_ptr    <= w_rr_ptr_nxt;
            r_sel       <= w_sel_nxt;
            r_valid     <= w_valid_nxt;
            r_ch_done   <= w_ch_done_nxt;
            r_beat_cnt  <= w_beat_cnt_nxt;
            r_dwell_lat <= w_dwell_lat_nxt;
        end
    end

    assign sel1    = r_sel[1];
    assign sel0    = r_sel[0];
    assign valid   = r_valid;
    assign ch_done = r_ch_done;
    assign busy    = (r_state == GRANT);

endmodule
`default_nettype wire

// File: tb/tb_mux4_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux4_scan_ctrl
// Purpose  : Directed bench for mux4_scan_ctrl with a grant-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux4_scan_ctrl;

    localparam int DWELL_W = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               en;
    logic [3:0]         req;
    logic [DWELL_W-1:0] dwell;
    logic               ready;
    logic               sel1;
    logic               sel0;
    logic               valid;
    logic               ch_done;
    logic               busy;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mux4_scan_ctrl #(.DWELL_W(DWELL_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .req     (req),
        .dwell   (dwell),
        .ready   (ready),
        .sel1    (sel1),
        .sel0    (sel0),
        .valid   (valid),
        .ch_done (ch_done),
        .busy    (busy)
    );

    // Reference model: a grant is "channel m_ch owns the mux for m_left more beats".
    bit m_live  = 1'b0;
    bit m_grant = 1'b0;
    bit m_done  = 1'b0;
    int m_ch    = 0;
    int m_ptr   = 0;
    int m_left  = 0;

    function automatic int pick(input int ptr, input logic [3:0] rq);
        for (int k = 0; k < 4; k++)
            if (rq[(ptr + k) % 4]) return (ptr + k) % 4;
        return ptr;
    endfunction

    always @(posedge clk) begin
        bit start;
        m_live = 1'b1;
        if (rst) begin
            m_grant = 1'b0; m_done = 1'b0; m_ch = 0; m_ptr = 0; m_left = 0;
        end else begin
            m_done = 1'b0;
            start  = 1'b0;
            if (!m_grant) begin
                start = en && (req != 4'b0000);
            end else if (ready) begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_done  = 1'b1;
                    m_ptr   = (m_ch + 1) % 4;
                    start   = en && (req != 4'b0000);
                    m_grant = 1'b0;
                end
            end
            if (start) begin
                m_grant = 1'b1;
                m_ch    = pick(m_ptr, req);
                m_left  = (dwell == 0) ? 1 : int'(dwell);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_live) begin
            check("model_sel",     {30'd0, sel1, sel0}, m_ch);
            check("model_valid",   {31'd0, valid},      {31'd0, m_grant});
            check("model_busy",    {31'd0, busy},       {31'd0, m_grant});
            check("model_ch_done", {31'd0, ch_done},    {31'd0, m_done});
        end
    end

    // Hand-computed expectations, applied to both DUT and model.
    task automatic pin(input string tag, input int e_sel, input int e_valid, input int e_done);
        check({tag, "_sel"},     {30'd0, sel1, sel0}, e_sel);
        check({tag, "_valid"},   {31'd0, valid},      e_valid);
        check({tag, "_busy"},    {31'd0, busy},       e_valid);
        check({tag, "_ch_done"}, {31'd0, ch_done},    e_done);
        check({tag, "_msel"},    m_ch,                e_sel);
        check({tag, "_mvalid"},  {31'd0, m_grant},    e_valid);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int sweep_sel [4] = '{1, 2, 3, 0};
    int rdy_pat   [5] = '{1, 0, 0, 1, 1};
    int done_pat  [5] = '{0, 0, 0, 0, 1};

    initial begin
        rst = 1'b1; en = 1'b0; req = 4'b1111; dwell = 4'd1; ready = 1'b0;
        step(2);
        pin("reset", 0, 0, 0);
        rst = 1'b0;
        step(3);
        pin("idle_en0", 0, 0, 0);

        // Round-robin sweep, one beat per grant
        en = 1'b1; req = 4'b1111; dwell = 4'd1; ready = 1'b1;
        step(1);
        pin("sweep0", 0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            step(1);
            pin($sformatf("sweep%0d", i + 1), sweep_sel[i], 1, 1);
        end
        en = 1'b0;
        step(1);
        pin("sweep_end", 0, 0, 1);

        // Dwell 3 with stalls, then channel 2 re-granted
        req = 4'b0100; dwell = 4'd3; en = 1'b1; ready = 1'b1;
        step(1);
        pin("dwell_grant", 2, 1, 0);
        for (int i = 0; i < 5; i++) begin
            ready = rdy_pat[i][0];
            step(1);
            pin($sformatf("dwell_b%0d", i), 2, 1, done_pat[i]);
        end
        en = 1'b0; ready = 1'b1;
        step(3);
        pin("dwell_idle", 2, 0, 1);

        // Sparse requests across the wrap; dwell 0 acts as one beat
        req = 4'b1000; dwell = 4'd0; en = 1'b1;
        step(1);
        pin("wrap_ch3", 3, 1, 0);
        req = 4'b1001;
        step(1);
        pin("wrap_ch0", 0, 1, 1);
        req = 4'b1000;
        step(1);
        pin("wrap_ch3b", 3, 1, 1);
        en = 1'b0;
        step(1);
        pin("wrap_idle", 3, 0, 1);

        // Mid-grant req/dwell/en changes are ignored until completion
        req = 4'b0010; dwell = 4'd4; en = 1'b1; ready = 1'b1;
        step(1);
        pin("mid_grant", 1, 1, 0);
        step(1);
        pin("mid_b1", 1, 1, 0);
        req = 4'b0000; dwell = 4'd1;
        step(1);
        pin("mid_b2", 1, 1, 0);
        en = 1'b0;
        step(1);
        pin("mid_b3", 1, 1, 0);
        step(1);
        pin("mid_b4", 1, 0, 1);
        step(1);
        pin("mid_after", 1, 0, 0);

        // Reset in the middle of a 5-beat grant
        req = 4'b0100; dwell = 4'd5; en = 1'b1; ready = 1'b1;
        step(1);
        pin("rstmid_grant", 2, 1, 0);
        step(2);
        pin("rstmid_b2", 2, 1, 0);
        rst = 1'b1;
        step(1);
        pin("rstmid_rst", 0, 0, 0);
        rst = 1'b0;
        step(1);
        pin("rstmid_regrant", 2, 1, 0);
        for (int i = 0; i < 4; i++) begin
            step(1);
            pin($sformatf("rstmid_b%0d", i + 1), 2, 1, 0);
        end
        step(1);
        pin("rstmid_b5", 2, 1, 1);
        en = 1'b0;
        step(5);
        pin("final_idle", 2, 0, 1);
        step(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
